// File: rtl/prog_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : prog_mem_ctrl
// Brief    : Writable program memory; cleared to a fill pattern after reset,
//            loaded through a write port, read through a registered fetch port.
// Revision : 1.0  initial release
// ============================================================================
module prog_mem_ctrl #(
    parameter int                WORD_W      = 16,
    parameter int                DEPTH       = 64,
    parameter int                ADDR_W      = 16,
    parameter logic [WORD_W-1:0] FILL_FNCODE = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_fncode,
    input  logic [WORD_W-1:0] wr_data,
    output logic              wr_err,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] addr,
    output logic              fetch_valid,
    output logic [WORD_W-1:0] fncode,
    output logic [WORD_W-1:0] data,
    output logic              addr_err,
    output logic              ready
);

    localparam int                  c_idx_w     = $clog2(DEPTH);
    // One extra bit so DEPTH == 2**ADDR_W is still representable.
    localparam logic [ADDR_W:0]     c_depth     = (ADDR_W + 1)'(DEPTH);
    localparam logic [c_idx_w-1:0]  c_last_ptr  = c_idx_w'(DEPTH - 1);
    localparam logic [2*WORD_W-1:0] c_fill_word = {FILL_FNCODE, {WORD_W{1'b0}}};

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_idx_w-1:0]    r_clr_ptr;
    logic [2*WORD_W-1:0]   r_mem [DEPTH];

    logic                  w_clr_last;
    logic                  w_wr_in_range;
    logic                  w_rd_in_range;
    logic                  w_mem_we;
    logic [c_idx_w-1:0]    w_mem_wa;
    logic [2*WORD_W-1:0]   w_mem_wd;

    logic                  r_fetch_valid;
    logic                  r_addr_err;
    logic [WORD_W-1:0]     r_fncode;
    logic [WORD_W-1:0]     r_data;
    logic                  r_wr_err;

    assign w_clr_last    = (r_clr_ptr == c_last_ptr);
    assign w_wr_in_range = ({1'b0, wr_addr} < c_depth);
    assign w_rd_in_range = ({1'b0, addr} < c_depth);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_CLEAR && w_clr_last) begin
            w_state_nxt = ST_READY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clr_ptr <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_clr_ptr <= r_clr_ptr + c_idx_w'(1);
        end
    end

    // Single write port shared by the clear sweep and the load path.
    always_comb begin
        w_mem_we = 1'b0;
        w_mem_wa = r_clr_ptr;
        w_mem_wd = c_fill_word;
        if (!rst) begin
            if (r_state == ST_CLEAR) begin
                w_mem_we = 1'b1;
            end else if (wr_en && w_wr_in_range) begin
                w_mem_we = 1'b1;
                w_mem_wa = wr_addr[c_idx_w-1:0];
                w_mem_wd = {wr_fncode, wr_data};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_wa] <= w_mem_wd;
        end
    end

    // Reading r_mem here before the write lands gives read-before-write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_valid <= 1'b0;
            r_addr_err    <= 1'b0;
            r_fncode      <= '0;
            r_data        <= '0;
            r_wr_err      <= 1'b0;
        end else begin
            r_fetch_valid <= 1'b0;
            r_wr_err      <= wr_en && ((r_state == ST_CLEAR) || !w_wr_in_range);
            if (r_state == ST_READY && fetch_req) begin
                r_fetch_valid <= 1'b1;
                if (w_rd_in_range) begin
                    {r_fncode, r_data} <= r_mem[addr[c_idx_w-1:0]];
                    r_addr_err         <= 1'b0;
                end else begin
                    {r_fncode, r_data} <= c_fill_word;
                    r_addr_err         <= 1'b1;
                end
            end
        end
    end

    assign ready       = (r_state == ST_READY);
    assign fetch_valid = r_fetch_valid;
    assign addr_err    = r_addr_err;
    assign fncode      = r_fncode;
    assign data        = r_data;
    assign wr_err      = r_wr_err;

endmodule
`default_nettype wire

// File: tb/tb_prog_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_mem_ctrl
// Brief    : Directed self-checking bench for prog_mem_ctrl.
// Revision : 1.0  initial release
// ============================================================================
module tb_prog_mem_ctrl;

    localparam int          c_word_w = 16;
    localparam int          c_depth  = 64;
    localparam int          c_addr_w = 16;
    localparam logic [15:0] c_fill   = 16'hF00D;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [15:0] wr_addr = '0;
    logic [15:0] wr_fncode = '0;
    logic [15:0] wr_data = '0;
    logic        wr_err;
    logic        fetch_req = 1'b0;
    logic [15:0] addr = '0;
    logic        fetch_valid;
    logic [15:0] fncode;
    logic [15:0] data;
    logic        addr_err;
    logic        ready;

    int n_vec = 0;
    int n_err = 0;

    logic [33:0] w_fetch;
    logic [37:0] w_all;
    assign w_fetch = {fetch_valid, addr_err, fncode, data};
    assign w_all   = {ready, fetch_valid, addr_err, wr_err, fncode, data};

    prog_mem_ctrl #(
        .WORD_W      (c_word_w),
        .DEPTH       (c_depth),
        .ADDR_W      (c_addr_w),
        .FILL_FNCODE (c_fill)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_fncode   (wr_fncode),
        .wr_data     (wr_data),
        .wr_err      (wr_err),
        .fetch_req   (fetch_req),
        .addr        (addr),
        .fetch_valid (fetch_valid),
        .fncode      (fncode),
        .data        (data),
        .addr_err    (addr_err),
        .ready       (ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [15:0] a, input logic [15:0] f, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_fncode = f; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic fetch(input string tag, input logic [15:0] a, input logic [33:0] exp);
        fetch_req = 1'b1; addr = a;
        step();
        fetch_req = 1'b0;
        chk(tag, 64'(w_fetch), 64'(exp));
    endtask

    initial begin
        repeat (3) step();
        chk("reset_outputs", 64'(w_all), 64'd0);

        rst = 1'b0;
        for (int i = 1; i <= c_depth; i++) begin
            step();
            chk("clear_ready", 64'(ready), 64'(i == c_depth));
        end

        fetch_req = 1'b1;
        for (int i = 0; i < c_depth; i++) begin
            addr = 16'(i);
            step();
            chk("fill_entry", 64'(w_fetch), 64'({2'b10, c_fill, 16'h0000}));
        end
        fetch_req = 1'b0;
        step();
        chk("valid_drop_hold", 64'(w_fetch), 64'({2'b00, c_fill, 16'h0000}));

        write(16'd0, 16'h0000, 16'h0001);
        write(16'd1, 16'h0100, 16'h0000);
        chk("load_no_wr_err", 64'(wr_err), 64'd0);
        fetch_req = 1'b1; addr = 16'd0;
        step();
        chk("run_addr0", 64'(w_fetch), 64'({2'b10, 16'h0000, 16'h0001}));
        addr = 16'd1;
        step();
        chk("run_addr1", 64'(w_fetch), 64'({2'b10, 16'h0100, 16'h0000}));
        fetch_req = 1'b0;
        step();
        chk("run_idle", 64'(fetch_valid), 64'd0);

        write(16'd64, 16'hDEAD, 16'hBEEF);
        chk("wr_oor_err", 64'(wr_err), 64'd1);
        step();
        chk("wr_err_pulse", 64'(wr_err), 64'd0);
        fetch("mem0_intact", 16'd0, {2'b10, 16'h0000, 16'h0001});
        fetch("rd_ffff", 16'hFFFF, {2'b11, c_fill, 16'h0000});
        fetch("rd_64", 16'd64, {2'b11, c_fill, 16'h0000});
        write(16'd63, 16'h6363, 16'h3636);
        fetch("rd_63", 16'd63, {2'b10, 16'h6363, 16'h3636});

        write(16'd5, 16'h1111, 16'h2222);
        wr_en = 1'b1; wr_addr = 16'd5; wr_fncode = 16'h3333; wr_data = 16'h4444;
        fetch("collide_old", 16'd5, {2'b10, 16'h1111, 16'h2222});
        wr_en = 1'b0;
        fetch("collide_new", 16'd5, {2'b10, 16'h3333, 16'h4444});

        fetch_req = 1'b1; addr = 16'd5;
        step();
        rst = 1'b1;
        wr_en = 1'b1; wr_addr = 16'd2; wr_fncode = 16'h7777; wr_data = 16'h8888;
        step();
        chk("rst_in_fetch", 64'(w_all), 64'd0);
        fetch_req = 1'b0; wr_en = 1'b0;
        step();

        rst = 1'b0;
        for (int i = 1; i <= 30; i++) step();
        chk("mid_clear_not_ready", 64'(ready), 64'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 1; i <= c_depth; i++) begin
            if (i == 10) begin
                wr_en = 1'b1; wr_addr = 16'd7; wr_fncode = 16'hAAAA; wr_data = 16'h5555;
                fetch_req = 1'b1; addr = 16'd7;
            end
            step();
            if (i == 10) begin
                chk("early_wr_err", 64'(wr_err), 64'd1);
                chk("early_no_fetch", 64'(fetch_valid), 64'd0);
                wr_en = 1'b0; fetch_req = 1'b0;
            end
            chk("reclear_ready", 64'(ready), 64'(i == c_depth));
        end
        fetch("early_addr_fill", 16'd7, {2'b10, c_fill, 16'h0000});
        fetch("rst_wr_dropped", 16'd2, {2'b10, c_fill, 16'h0000});
        fetch("old_0_cleared", 16'd0, {2'b10, c_fill, 16'h0000});
        fetch("old_5_cleared", 16'd5, {2'b10, c_fill, 16'h0000});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prog_mem_ctrl.md
# prog_mem_ctrl

Parametrised, writable program memory for the arithmetic processor. It replaces the fixed, combinational instruction table with a synchronous RAM that holds one instruction per address: a function-code word plus a data word. The RAM is cleared to a fill pattern after reset, loaded through a write port, and read through a registered fetch port with a valid strobe. It sits between the program counter / fetch logic and the decoder, and adds range checking on both read and write.

## Interface
- WORD_W, 16, width of both the fncode and data fields
- DEPTH, 64, number of instruction entries (≥2)
- ADDR_W, 16, width of address ports (2^ADDR_W ≥ DEPTH)
- FILL_FNCODE, 16'h0000, fncode written to every entry during clear; data field is cleared to 0
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write strobe, one entry per cycle
- wr_addr  in  ADDR_W  write address
- wr_fncode  in  WORD_W  fncode to store
- wr_data  in  WORD_W  data word to store
- wr_err  out  1  one-cycle pulse: the write was dropped
- fetch_req  in  1  fetch strobe
- addr  in  ADDR_W  fetch address
- fetch_valid  out  1  one-cycle pulse: fncode/data/addr_err are valid
- fncode  out  WORD_W  fetched function code
- data  out  WORD_W  fetched data word
- addr_err  out  1  qualifies fetch_valid: addr ≥ DEPTH
- ready  out  1  clear finished; fetch and write are accepted

## Operation
- Two states: CLEAR and READY. A clear pointer clr_ptr counts 0..DEPTH-1.
- rst high → state=CLEAR, clr_ptr=0. All outputs are 0: ready, fetch_valid, fncode, data, addr_err, wr_err. The RAM is not written while rst is high.
- CLEAR, rst low, on each edge: mem[clr_ptr] ← {FILL_FNCODE, 0}, then clr_ptr++. On the edge that writes DEPTH-1, state→READY and ready→1.
- In CLEAR:
  - fetch_req is ignored: no fetch_valid, no addr_err.
  - wr_en drops the write and pulses wr_err.
- In READY, writes:
  - wr_en with wr_addr < DEPTH → mem[wr_addr] ← {wr_fncode, wr_data}.
  - wr_en with wr_addr ≥ DEPTH → write dropped, wr_err pulses.
- In READY, fetch:
  - fetch_req with addr < DEPTH → next cycle fncode/data = mem[addr], fetch_valid=1, addr_err=0.
  - fetch_req with addr ≥ DEPTH → next cycle fncode=FILL_FNCODE, data=0, fetch_valid=1, addr_err=1.
- Read-before-write: a fetch and a write to the same address in the same cycle return the old contents. The new contents are visible to a fetch issued the following cycle.
- Address comparisons use the full ADDR_W bits. There is no wrap or truncation.
- ready stays at 1 until the next rst. Only rst re-enters CLEAR.

## Timing
- Fetch latency is 1 cycle: request at edge N, outputs valid after edge N+1.
- Back-to-back fetches are supported, one per cycle, with fetch_valid held high continuously.
- fncode, data and addr_err hold their last value when fetch_valid is 0.
- wr_err asserts in the cycle after the offending wr_en, for 1 cycle.
- ready rises exactly DEPTH rising edges after the first edge with rst low.
- rst asserted mid-CLEAR: clearing restarts from clr_ptr=0.
- rst asserted in READY:
  - ready drops on that edge.
  - An in-flight fetch produces no fetch_valid.
  - A write in the same cycle as rst is dropped, with no wr_err.
- Writes are not retained across a reset: the subsequent clear overwrites every entry.

## Test plan
- Reset/clear: DEPTH=64. Hold rst for 3 cycles, then release → ready stays 0 for 63 edges and is 1 after the 64th. Fetch addr 0..63 → every entry returns fncode=FILL_FNCODE, data=0, addr_err=0.
- Program load and run: in READY, write addr 0 = {16'h0000, 16'h0001} and addr 1 = {16'h0100, 16'h0000}. Fetch addr 0, 1 back-to-back → fetch_valid high for 2 consecutive cycles, returning those two words in order, each with 1-cycle latency.
- Range checks:
  - Write wr_addr=64 → wr_err pulse, and mem[0] is unchanged.
  - Fetch addr=16'hFFFF → fetch_valid=1, addr_err=1, fncode=FILL_FNCODE, data=0.
- Collision: mem[5]=A. In the same cycle, write mem[5]←B and fetch 5 → returns A. Fetch 5 again next cycle → returns B.
- Early access: release rst, and at the 10th cycle of CLEAR assert wr_en and fetch_req → wr_err pulses, no fetch_valid. After ready, fetching that address returns fill.
- Reset mid-operation:
  - Assert rst for 1 cycle at clear pointer 30 → ready rises 64 edges after release.
  - Assert rst during an active fetch in READY → no fetch_valid pulse, and all outputs are 0.
